// File: rtl/pht_two_level.sv
// Pattern history table: second level of the two-level local branch
// predictor. Two IF-stage read ports return 2-bit saturating counters
// indexed by {pc[2 +: PC_BITS], history}. Two EX-stage resolved branches
// train the table through one registered update stage (U1). Reads see U1
// through a bypass, so every prediction reflects all training already
// accepted.
module pht_two_level #(
  parameter int H_W     = 4,
  parameter int PC_BITS = 2,
  parameter int XLEN    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0][XLEN-1:0]       if_pc_in,
  input  logic [1:0][H_W-1:0]        bht_if_in,
  input  logic [1:0]                 wr_en,
  input  logic [1:0][XLEN-1:0]       ex_pc_in,
  input  logic [1:0][H_W-1:0]        bht_ex_in,
  input  logic [1:0]                 take_branch,
  output logic [1:0]                 predict_taken,
  output logic [1:0][1:0]            pht_state_out
);

  localparam int IDX_W = PC_BITS + H_W;
  localparam int DEPTH = 1 << IDX_W;

  // Counter table, reset to weak not-taken.
  logic [1:0] pht [DEPTH];

  // U1 keeps the post-update counter value rather than the raw direction:
  // the value it will write is exactly the value the bypass must return,
  // so both paths share one computation.
  logic [1:0]            u1_valid;
  logic [1:0][IDX_W-1:0] u1_idx;
  logic [1:0][1:0]       u1_val;

  logic [1:0][IDX_W-1:0] if_idx;
  logic [1:0][IDX_W-1:0] ex_idx;
  logic [1:0][1:0]       ex_base;
  logic [1:0][1:0]       ex_next;

  // PC bits outside the index field do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_in[0][XLEN-1:2+PC_BITS], if_pc_in[0][1:0],
                            if_pc_in[1][XLEN-1:2+PC_BITS], if_pc_in[1][1:0],
                            ex_pc_in[0][XLEN-1:2+PC_BITS], ex_pc_in[0][1:0],
                            ex_pc_in[1][XLEN-1:2+PC_BITS], ex_pc_in[1][1:0]};

  // Saturating 2-bit counter step: taken counts up to 11, not-taken down to 00.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) res = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

  // Array value overlaid with U1; slot 1 is younger and already holds the
  // merged result when both slots target one entry, so it takes priority.
  function automatic logic [1:0] overlay(
    input logic [IDX_W-1:0]        idx,
    input logic [1:0]              arr_val,
    input logic [1:0]              valid,
    input logic [1:0][IDX_W-1:0]   uidx,
    input logic [1:0][1:0]         uval
  );
    logic [1:0] res;
    res = arr_val;
    if (valid[1] && uidx[1] == idx) res = uval[1];
    else if (valid[0] && uidx[0] == idx) res = uval[0];
    return res;
  endfunction

  // Form the table indices for both IF reads and both EX updates.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      if_idx[s] = {if_pc_in[s][2 +: PC_BITS], bht_if_in[s]};
      ex_idx[s] = {ex_pc_in[s][2 +: PC_BITS], bht_ex_in[s]};
    end
  end

  // IF read path: array lookup with U1 bypass, no bypass of raw EX inputs.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pht_state_out[s] = overlay(if_idx[s], pht[if_idx[s]], u1_valid, u1_idx, u1_val);
      predict_taken[s] = pht_state_out[s][1];
    end
  end

  // Next U1 values: each EX update starts from the bypassed counter so
  // back-to-back training of one entry is never lost; slot 1 chains on
  // slot 0 when both hit the same entry in the same cycle.
  always_comb begin
    ex_base[0] = overlay(ex_idx[0], pht[ex_idx[0]], u1_valid, u1_idx, u1_val);
    ex_next[0] = sat_step(ex_base[0], take_branch[0]);
    if (wr_en[0] && ex_idx[0] == ex_idx[1]) ex_base[1] = ex_next[0];
    else ex_base[1] = overlay(ex_idx[1], pht[ex_idx[1]], u1_valid, u1_idx, u1_val);
    ex_next[1] = sat_step(ex_base[1], take_branch[1]);
  end

  // U1 capture register; reset discards any in-flight update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      u1_valid <= '0;
      u1_idx   <= '0;
      u1_val   <= '0;
    end else begin
      u1_valid <= wr_en;
      u1_idx   <= ex_idx;
      u1_val   <= ex_next;
    end
  end

  // Commit U1 into the array; on a shared entry slot 1's merged value wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (u1_valid[1] && u1_idx[1] == IDX_W'(i)) pht[i] <= u1_val[1];
        else if (u1_valid[0] && u1_idx[0] == IDX_W'(i)) pht[i] <= u1_val[0];
      end
    end
  end

endmodule

// File: tb/tb_pht_two_level.sv
// Testbench for pht_two_level: directed scenarios with hand-derived
// counter values plus randomized traffic against a table model in which
// every EX update takes effect, in program order, at the edge it is
// presented on.
module tb_pht_two_level;

  logic                  clock;
  logic                  reset;
  logic [1:0][31:0]      if_pc_in;
  logic [1:0][3:0]       bht_if_in;
  logic [1:0]            wr_en;
  logic [1:0][31:0]      ex_pc_in;
  logic [1:0][3:0]       bht_ex_in;
  logic [1:0]            take_branch;
  logic [1:0]            predict_taken;
  logic [1:0][1:0]       pht_state_out;

  int tests_run;
  int tests_failed;
  int model [64];

  pht_two_level dut (
    .clock(clock),
    .reset(reset),
    .if_pc_in(if_pc_in),
    .bht_if_in(bht_if_in),
    .wr_en(wr_en),
    .ex_pc_in(ex_pc_in),
    .bht_ex_in(bht_ex_in),
    .take_branch(take_branch),
    .predict_taken(predict_taken),
    .pht_state_out(pht_state_out)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Saturating counter as plain integer arithmetic.
  function automatic int sat(input int c, input bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Build a PC whose index field selects idx[5:4], rest random.
  function automatic logic [31:0] make_pc(input int idx);
    logic [31:0] pc;
    pc = $urandom();
    pc[3:2] = 2'((idx / 16) % 4);
    return pc;
  endfunction

  task automatic drive_if(input int s, input int idx);
    if_pc_in[s]  = make_pc(idx);
    bht_if_in[s] = 4'(idx % 16);
  endtask

  task automatic drive_ex(input int s, input bit en, input int idx, input bit t);
    wr_en[s]       = en;
    ex_pc_in[s]    = make_pc(idx);
    bht_ex_in[s]   = 4'(idx % 16);
    take_branch[s] = t;
  endtask

  // Advance one cycle and fold this cycle's EX updates into the model.
  task automatic step();
    @(posedge clock);
    for (int s = 0; s < 2; s++) begin
      if (wr_en[s]) begin
        int idx;
        idx = int'(ex_pc_in[s][3:2]) * 16 + int'(bht_ex_in[s]);
        model[idx] = sat(model[idx], take_branch[s]);
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    wr_en = 2'b00;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 1;
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    wr_en = 2'b00;
    reset = 1'b1;
    drive_if(0, 37);
    drive_if(1, 37);
    #2;
    tests_run++;
    if (pht_state_out !== 4'b0101 || predict_taken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_read: state=%b pred=%b, expected state=0101 pred=00",
               pht_state_out, predict_taken);
    end
    for (int k = 0; k < 4; k++) begin
      drive_if(0, int'($urandom_range(0, 63)));
      drive_if(1, int'($urandom_range(0, 63)));
      #1;
      tests_run++;
      if (pht_state_out !== 4'b0101 || predict_taken !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL reset_any_idx: state=%b pred=%b, expected state=0101 pred=00",
                 pht_state_out, predict_taken);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_saturate();
    bit dirs [10]     = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [1:0] exp [10] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11,
                             2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    apply_reset();
    drive_ex(1, 1'b0, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      drive_ex(0, 1'b1, 37, dirs[c]);
      drive_if(0, 37);
      drive_if(1, 37);
      #1;
      tests_run++;
      if (pht_state_out[0] !== exp[c] || pht_state_out[1] !== exp[c] ||
          predict_taken !== {2{exp[c][1]}}) begin
        tests_failed++;
        $display("[TB] FAIL saturate_c%0d: state=%b pred=%b, expected %b per slot",
                 c, pht_state_out, predict_taken, exp[c]);
      end
      step();
    end
    wr_en = 2'b00;
  endtask

  task automatic test_dual_same();
    apply_reset();
    drive_ex(1, 1'b0, 0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      drive_ex(0, 1'b1, 37, 1'b1);
      step();
    end
    drive_ex(0, 1'b1, 37, 1'b1);
    drive_ex(1, 1'b1, 37, 1'b0);
    step();
    wr_en = 2'b00;
    drive_if(0, 37);
    drive_if(1, 37);
    #1;
    tests_run++;
    if (pht_state_out[0] !== 2'b10 || pht_state_out[1] !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL dual_same_T_NT: state=%b, expected 10 per slot", pht_state_out);
    end
    drive_ex(0, 1'b1, 37, 1'b0);
    step();
    drive_ex(0, 1'b1, 37, 1'b0);
    step();
    drive_ex(0, 1'b1, 37, 1'b0);
    drive_ex(1, 1'b1, 37, 1'b1);
    step();
    wr_en = 2'b00;
    #1;
    tests_run++;
    if (pht_state_out[0] !== 2'b01 || predict_taken[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dual_same_NT_T: state=%b pred=%b, expected 01 pred 0",
               pht_state_out[0], predict_taken[0]);
    end
    step();
    tests_run++;
    if (pht_state_out[1] !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL dual_same_array: state=%b, expected 01", pht_state_out[1]);
    end
  endtask

  task automatic test_dual_diff();
    apply_reset();
    drive_ex(0, 1'b1, 37, 1'b1);
    drive_ex(1, 1'b1, 5, 1'b0);
    step();
    wr_en = 2'b00;
    drive_if(0, 37);
    drive_if(1, 5);
    #1;
    tests_run++;
    if (pht_state_out[0] !== 2'b10 || pht_state_out[1] !== 2'b00 || predict_taken !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL dual_diff: state=%b pred=%b, expected state=0010 pred=01",
               pht_state_out, predict_taken);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] exp [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    apply_reset();
    drive_ex(1, 1'b0, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive_ex(0, c == 0, 37, 1'b1);
      drive_if(0, 37);
      drive_if(1, 21);
      #1;
      tests_run++;
      if (pht_state_out[0] !== exp[c] || pht_state_out[1] !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL same_cycle_c%0d: state=%b, expected slot0=%b slot1=01",
                 c, pht_state_out, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    drive_ex(0, 1'b1, 37, 1'b1);
    drive_ex(1, 1'b1, 37, 1'b1);
    step();
    wr_en = 2'b00;
    reset = 1'b1;
    drive_if(0, 37);
    drive_if(1, 37);
    #1;
    tests_run++;
    if (pht_state_out !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_during: state=%b, expected 0101", pht_state_out);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 1;
    step();
    #1;
    tests_run++;
    if (pht_state_out !== 4'b0101 || predict_taken !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_after: state=%b pred=%b, expected 0101 pred 00",
               pht_state_out, predict_taken);
    end
  endtask

  task automatic test_random();
    int pool [6] = '{37, 5, 21, 0, 63, 38};
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      int ia;
      int ib;
      for (int s = 0; s < 2; s++)
        drive_ex(s, 1'($urandom()), pool[$urandom_range(0, 5)], 1'($urandom()));
      ia = pool[$urandom_range(0, 5)];
      ib = pool[$urandom_range(0, 5)];
      drive_if(0, ia);
      drive_if(1, ib);
      #1;
      tests_run++;
      if (pht_state_out[0] !== 2'(model[ia]) || pht_state_out[1] !== 2'(model[ib]) ||
          predict_taken[0] !== (model[ia] >= 2) || predict_taken[1] !== (model[ib] >= 2)) begin
        tests_failed++;
        $display("[TB] FAIL random_c%0d: state=%b pred=%b, expected slot0=%0d slot1=%0d",
                 c, pht_state_out, predict_taken, model[ia], model[ib]);
      end
      step();
    end
    wr_en = 2'b00;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    wr_en        = 2'b00;
    take_branch  = 2'b00;
    if_pc_in     = '0;
    bht_if_in    = '0;
    ex_pc_in     = '0;
    bht_ex_in    = '0;
    test_reset();
    test_saturate();
    test_dual_same();
    test_dual_diff();
    test_same_cycle();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
